match_resp_router: RTL and testbench

Routes match results from the `NUM_MATCH_PE` match PEs back to the job PE that issued each request, selected by the `job_pe_id` carried with every response. It sits directly downstream of the match PE array and upstream of the job PEs. Each job PE has its own output port with an independent round-robin arbiter and a one-entry registered output slot, so responses for different job PEs never block one another.

---
 rtl/match_resp_router.sv | 105 ++++++++++
 tb/tb_match_resp_router.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/match_resp_router.sv
// Response crossbar from the match PE array back to the issuing job PEs.
// Each job PE port has its own round-robin arbiter and a one-entry output slot.
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif

module match_resp_router #(
    parameter int NUM_MATCH_PE = 4,
    parameter int NUM_JOB_PE   = (1 << `NUM_JOB_PE_LOG2),
    parameter int TAG_W        = 8,
    parameter int LEN_W        = `MAX_MATCH_LEN_LOG2 + 1,
    localparam int JW          = `NUM_JOB_PE_LOG2,
    localparam int SW          = $clog2(NUM_MATCH_PE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_MATCH_PE-1:0]      i_match_resp_valid,
    output logic [NUM_MATCH_PE-1:0]      o_match_resp_ready,
    input  logic [NUM_MATCH_PE*JW-1:0]   i_match_resp_job_pe_id,
    input  logic [NUM_MATCH_PE*TAG_W-1:0] i_match_resp_tag,
    input  logic [NUM_MATCH_PE*LEN_W-1:0] i_match_resp_match_len,
    output logic [NUM_JOB_PE-1:0]        o_job_resp_valid,
    input  logic [NUM_JOB_PE-1:0]        i_job_resp_ready,
    output logic [NUM_JOB_PE*TAG_W-1:0]  o_job_resp_tag,
    output logic [NUM_JOB_PE*LEN_W-1:0]  o_job_resp_match_len,
    output logic [NUM_JOB_PE*SW-1:0]     o_job_resp_src_pe
);

    logic [NUM_JOB_PE-1:0]       slot_valid;
    logic [NUM_JOB_PE-1:0]       slot_free;
    logic [NUM_JOB_PE-1:0]       gnt_any;
    logic [SW-1:0]               gnt_idx [NUM_JOB_PE];
    logic [SW-1:0]               rr_ptr  [NUM_JOB_PE];
    logic [NUM_JOB_PE*TAG_W-1:0] tag_q;
    logic [NUM_JOB_PE*LEN_W-1:0] len_q;
    logic [NUM_JOB_PE*SW-1:0]    src_q;

    assign slot_free = ~slot_valid | i_job_resp_ready;

    // Scan inputs starting at rr_ptr; the index wraps because NUM_MATCH_PE is a power of two.
    always_comb begin : arb
        logic [SW-1:0] idx;
        logic          found;
        idx     = '0;
        found   = 1'b0;
        gnt_any = '0;
        for (int j = 0; j < NUM_JOB_PE; j++) begin
            gnt_idx[j] = '0;
            found      = 1'b0;
            for (int k = 0; k < NUM_MATCH_PE; k++) begin
                idx = rr_ptr[j] + SW'(k);
                if (!found && i_match_resp_valid[idx] &&
                    i_match_resp_job_pe_id[idx*JW +: JW] == JW'(j)) begin
                    found      = 1'b1;
                    gnt_idx[j] = idx;
                end
            end
            gnt_any[j] = found;
        end
    end

    always_comb begin : rdy
        logic [JW-1:0] dst;
        dst                = '0;
        o_match_resp_ready = '0;
        for (int i = 0; i < NUM_MATCH_PE; i++) begin
            dst = i_match_resp_job_pe_id[i*JW +: JW];
            o_match_resp_ready[i] = slot_free[dst] && gnt_any[dst] &&
                                    gnt_idx[dst] == SW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            tag_q      <= '0;
            len_q      <= '0;
            src_q      <= '0;
            for (int j = 0; j < NUM_JOB_PE; j++) begin
                rr_ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_JOB_PE; j++) begin
                if (gnt_any[j] && slot_free[j]) begin
                    slot_valid[j]            <= 1'b1;
                    tag_q[j*TAG_W +: TAG_W]  <= i_match_resp_tag[gnt_idx[j]*TAG_W +: TAG_W];
                    len_q[j*LEN_W +: LEN_W]  <= i_match_resp_match_len[gnt_idx[j]*LEN_W +: LEN_W];
                    src_q[j*SW +: SW]        <= gnt_idx[j];
                    rr_ptr[j]                <= gnt_idx[j] + 1'b1;
                end else if (slot_valid[j] && i_job_resp_ready[j]) begin
                    slot_valid[j] <= 1'b0;
                end
            end
        end
    end

    assign o_job_resp_valid     = slot_valid;
    assign o_job_resp_tag       = tag_q;
    assign o_job_resp_match_len = len_q;
    assign o_job_resp_src_pe    = src_q;

endmodule

// File: tb/tb_match_resp_router.sv
// Directed bench for match_resp_router: 4 match PEs, 4 job PEs,
// 8-bit tags, 6-bit lengths.
module tb_match_resp_router;

    logic        clk;
    logic        rst_n;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [7:0]  m_id;
    logic [31:0] m_tag;
    logic [23:0] m_len;
    logic [3:0]  j_valid;
    logic [3:0]  j_ready;
    logic [31:0] j_tag;
    logic [23:0] j_len;
    logic [7:0]  j_src;

    int vecs = 0;
    int errs = 0;

    match_resp_router dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_match_resp_valid     (m_valid),
        .o_match_resp_ready     (m_ready),
        .i_match_resp_job_pe_id (m_id),
        .i_match_resp_tag       (m_tag),
        .i_match_resp_match_len (m_len),
        .o_job_resp_valid       (j_valid),
        .i_job_resp_ready       (j_ready),
        .o_job_resp_tag         (j_tag),
        .o_job_resp_match_len   (j_len),
        .o_job_resp_src_pe      (j_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit v, input int id,
                         input int tag, input int len);
        m_valid[i]       = v;
        m_id[i*2 +: 2]   = id[1:0];
        m_tag[i*8 +: 8]  = tag[7:0];
        m_len[i*6 +: 6]  = len[5:0];
    endtask

    task automatic clr();
        m_valid = '0;
        m_id    = '0;
        m_tag   = '0;
        m_len   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        j_ready = 4'hF;
        clr();
        #1;
        chk("rst_valid", 32'(j_valid), 32'h0);
        chk("rst_tag", j_tag, 32'h0);
        #12 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(j_valid), 32'h0);
        chk("post_rst_len_src", {j_len, j_src}, 32'h0);

        // single response, input 2 -> job 1
        drive(2, 1'b1, 1, 8'h5A, 17);
        #1 chk("t1_ready", 32'(m_ready), 32'h4);
        tick();
        clr();
        chk("t1_valid", 32'(j_valid), 32'h2);
        chk("t1_tag", 32'(j_tag[15:8]), 32'h5A);
        chk("t1_len", 32'(j_len[11:6]), 32'd17);
        chk("t1_src", 32'(j_src[3:2]), 32'd2);
        tick();
        chk("t1_drain", 32'(j_valid), 32'h0);

        // all inputs to job 0: round robin 0,1,2,3,0,1
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) drive(i, 1'b1, 0, 8'h10 + i, i);
            #1 chk("rr_ready", 32'(m_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_src", 32'(j_src[1:0]), 32'(k % 4));
            chk("rr_tag", 32'(j_tag[7:0]), 32'(8'h10 + k % 4));
            chk("rr_valid", 32'(j_valid), 32'h1);
        end
        clr();
        tick();

        // job 3 stalled, job 0 streams
        j_ready = 4'h7;
        drive(0, 1'b1, 3, 8'h33, 3);
        #1 chk("bp_fill_ready", 32'(m_ready), 32'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 3, 8'h34, 4);
            drive(1, 1'b1, 0, 8'h40 + k, k);
            #1 chk("bp_ready", 32'(m_ready), 32'h2);
            tick();
            chk("bp_valid", 32'(j_valid), 32'h9);
            chk("bp_hold_tag", 32'(j_tag[31:24]), 32'h33);
            chk("bp_hold_src", 32'(j_src[7:6]), 32'd0);
            chk("bp_j0_tag", 32'(j_tag[7:0]), 32'(8'h40 + k));
        end
        clr();

        // drain and load job 3 in the same cycle
        drive(1, 1'b1, 3, 8'h07, 7);
        j_ready = 4'hF;
        #1 chk("dl_ready", 32'(m_ready), 32'h2);
        chk("dl_old_tag", 32'(j_tag[31:24]), 32'h33);
        tick();
        clr();
        chk("dl_valid", 32'(j_valid[3]), 32'h1);
        chk("dl_new_tag", 32'(j_tag[31:24]), 32'h07);
        chk("dl_new_src", 32'(j_src[7:6]), 32'd1);
        tick();
        chk("dl_empty", 32'(j_valid), 32'h0);

        // two inputs to different jobs in one cycle
        drive(0, 1'b1, 0, 8'hA0, 1);
        drive(3, 1'b1, 2, 8'hA2, 2);
        #1 chk("par_ready", 32'(m_ready), 32'h9);
        tick();
        clr();
        chk("par_valid", 32'(j_valid), 32'h5);
        chk("par_tag0", 32'(j_tag[7:0]), 32'hA0);
        chk("par_tag2", 32'(j_tag[23:16]), 32'hA2);
        chk("par_src2", 32'(j_src[5:4]), 32'd3);
        tick();

        // fill every slot, then async reset between edges
        j_ready = 4'h0;
        for (int i = 0; i < 4; i++) drive(i, 1'b1, i, 8'hC0 + i, i);
        #1 chk("full_ready", 32'(m_ready), 32'hF);
        tick();
        clr();
        chk("full_valid", 32'(j_valid), 32'hF);
        #3 rst_n = 1'b0;
        #1 chk("async_valid", 32'(j_valid), 32'h0);
        chk("async_tag", j_tag, 32'h0);
        #2 rst_n = 1'b1;
        j_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) drive(i, 1'b1, j, 8'hE0 + i, i);
            #1 chk("post_rst_grant", 32'(m_ready), 32'h1);
            tick();
            chk("post_rst_out", 32'(j_valid), 32'(1 << j));
            chk("post_rst_src", 32'(j_src[j*2 +: 2]), 32'd0);
        end
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
